axi_rd_arb: RTL and testbench
=============================

// Module: axi_rd_arb
// PURPOSE
//  Round-robin arbiter sharing one AXI4 read master port between N_REQ cache refill requesters
//  (e.g. I-cache and D-cache miss engines). One burst outstanding at a time: the winner owns the
//  AR and R channels from grant until its RLAST beat completes. Sits between the cache miss
//  controllers and the external AXI interconnect.
// PARAMETERS
//  N_REQ   2   number of requesters (>=2)
//  ADDR_W  32  AXI address width
//  DATA_W  32  AXI data width
//  ID_W    4   AXI ID width; ARID = requester index, zero-extended (requires N_REQ <= 2**ID_W)
// PORTS
//  clk          in   1             clock; all logic on posedge
//  reset_n      in   1             synchronous, active-low reset
//  req_arvalid  in   N_REQ         per-requester read request
//  req_araddr   in   N_REQ*ADDR_W  packed request addresses, requester i at [i*ADDR_W +: ADDR_W]
//  req_arlen    in   N_REQ*8       packed burst lengths (beats-1)
//  req_arready  out  N_REQ         one-hot acceptance pulse
//  req_rvalid   out  N_REQ         read beat valid, routed to owner only
//  req_rready   in   N_REQ         per-requester read ready
//  req_rdata    out  DATA_W        shared read data (qualified by req_rvalid)
//  req_rresp    out  2             shared read response
//  req_rlast    out  1             shared last-beat flag
//  m_arvalid/m_arready  out/in 1   AXI AR handshake
//  m_araddr     out  ADDR_W;  m_arlen out 8;  m_arid out ID_W;  m_arburst out 2 (const INCR=2'b01)
//  m_rvalid/m_rready    in/out 1   AXI R handshake
//  m_rdata in DATA_W; m_rresp in 2; m_rlast in 1; m_rid in ID_W
//  busy         out  1             high in AR or R state
//  proto_err    out  1             one-cycle pulse on beat-count or RID mismatch
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0, beat_cnt=0; m_arvalid, m_rready, req_arready, req_rvalid, busy,
//   proto_err all 0; m_araddr/m_arlen/m_arid 0. Reset mid-burst abandons it; no drain.
//  FSM IDLE -> AR -> R -> IDLE.
//  IDLE: if any req_arvalid, pick first set bit at or after rr_ptr (wrapping); pulse
//   req_arready[g] that cycle; register addr/len/id=g into m_ar*; owner<=g; -> AR.
//  AR: m_arvalid=1, m_ar* stable until m_arready; on handshake -> R, beat_cnt<=0.
//   First request at cycle t gives m_arvalid at t+1 (1-cycle latency).
//  R: req_rvalid[owner]=m_rvalid, others 0; m_rready=req_rready[owner] (combinational pass-through);
//   rdata/rresp/rlast pass through. Each m_rvalid&&m_rready increments beat_cnt.
//   On handshake with m_rlast: -> IDLE, rr_ptr<=(owner+1) mod N_REQ.
//  Errors (proto_err pulse next cycle, data still forwarded): m_rlast with beat_cnt!=arlen;
//   beat with beat_cnt==arlen and m_rlast=0 (FSM stays in R until RLAST); m_rid!=owner.
//  Back-to-back: one IDLE cycle between bursts; new request sampled in IDLE only.
//  Simultaneous requests: strict round-robin; a requester never waits more than N_REQ-1 grants.
//  m_rvalid outside R is ignored (m_rready=0). Requesters hold arvalid/addr/len until arready.
// STRUCTURE
//  Package axi_rd_arb_pkg: state enum {IDLE,AR,R}, AXI_BURST_INCR, AXI_RESP_* constants.
//  Sub-module rr_pick: combinational N_REQ-wide round-robin picker (req, ptr -> one-hot grant, valid).
// TESTING
//  Single req0, arlen=3, m_arready immediate -> m_arid=0, 4 beats to req0 only, IDLE after RLAST.
//  req0 and req1 held together, 3 bursts each -> grants alternate 0,1,0,1,0,1.
//  m_arready low 5 cycles -> m_arvalid/addr/len stable throughout, no req_rvalid toggles.
//  req_rready[owner] low on beat 2 -> m_rready low, beat held, beat_cnt unchanged.
//  arlen=3 but RLAST on beat 2 -> proto_err pulse, FSM returns IDLE; RID=1 for owner 0 -> proto_err.
//  reset_n low mid-R burst -> next cycle all outputs 0, state IDLE, rr_ptr=0.

Source files
------------

// File: rtl/axi_rd_arb_pkg.sv
// Shared types and AXI constants for the round-robin AXI read arbiter.
package axi_rd_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AR   = 2'd1,
        R    = 2'd2
    } state_t;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_rd_arb_rr_pick.sv
// Combinational round-robin picker: grants the first requester at or after ptr, wrapping.
module rr_pick
    import axi_rd_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic          valid
);

    int idx;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!valid && req[idx]) begin
                grant[idx] = 1'b1;
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_rd_arb.sv
// Shares one AXI4 read master between N_REQ refill requesters; one burst in flight at a time,
// the winner owns AR and R until its RLAST beat completes.
module axi_rd_arb
    import axi_rd_arb_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [N_REQ-1:0]        req_arvalid,
    input  logic [N_REQ*ADDR_W-1:0] req_araddr,
    input  logic [N_REQ*8-1:0]      req_arlen,
    output logic [N_REQ-1:0]        req_arready,
    output logic [N_REQ-1:0]        req_rvalid,
    input  logic [N_REQ-1:0]        req_rready,
    output logic [DATA_W-1:0]       req_rdata,
    output logic [1:0]              req_rresp,
    output logic                    req_rlast,
    output logic                    m_arvalid,
    input  logic                    m_arready,
    output logic [ADDR_W-1:0]       m_araddr,
    output logic [7:0]              m_arlen,
    output logic [ID_W-1:0]         m_arid,
    output logic [1:0]              m_arburst,
    input  logic                    m_rvalid,
    output logic                    m_rready,
    input  logic [DATA_W-1:0]       m_rdata,
    input  logic [1:0]              m_rresp,
    input  logic                    m_rlast,
    input  logic [ID_W-1:0]         m_rid,
    output logic                    busy,
    output logic                    proto_err
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t            state_reg;
    logic [PW-1:0]     rr_ptr_reg;
    logic [PW-1:0]     owner_reg;
    logic [7:0]        beat_cnt_reg;
    logic [N_REQ-1:0]  grant;
    logic              grant_valid;
    logic [PW-1:0]     grant_idx;

    rr_pick #(.N(N_REQ), .PW(PW)) u_pick (
        .req   (req_arvalid),
        .ptr   (rr_ptr_reg),
        .grant (grant),
        .valid (grant_valid)
    );

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                grant_idx = PW'(i);
            end
        end
    end

    // Acceptance is combinational so the requester sees it in the same IDLE cycle it is picked.
    assign req_arready = (reset_n && state_reg == IDLE && grant_valid) ? grant : '0;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_route
        assign req_rvalid[gi] = (state_reg == R) && (owner_reg == PW'(gi)) && m_rvalid;
    end

    assign m_rready  = (state_reg == R) && req_rready[owner_reg];
    assign req_rdata = m_rdata;
    assign req_rresp = m_rresp;
    assign req_rlast = m_rlast;
    assign m_arburst = AXI_BURST_INCR;
    assign busy      = (state_reg != IDLE);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            rr_ptr_reg   <= '0;
            owner_reg    <= '0;
            beat_cnt_reg <= '0;
            m_arvalid    <= 1'b0;
            m_araddr     <= '0;
            m_arlen      <= '0;
            m_arid       <= '0;
            proto_err    <= 1'b0;
        end else begin
            proto_err <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (grant_valid) begin
                        m_araddr  <= req_araddr[grant_idx*ADDR_W +: ADDR_W];
                        m_arlen   <= req_arlen[grant_idx*8 +: 8];
                        m_arid    <= ID_W'(grant_idx);
                        owner_reg <= grant_idx;
                        m_arvalid <= 1'b1;
                        state_reg <= AR;
                    end
                end
                AR: begin
                    if (m_arready) begin
                        m_arvalid    <= 1'b0;
                        beat_cnt_reg <= '0;
                        state_reg    <= R;
                    end
                end
                R: begin
                    if (m_rvalid && m_rready) begin
                        beat_cnt_reg <= beat_cnt_reg + 8'd1;
                        // Flags early/late RLAST and foreign IDs; the beat is still forwarded.
                        proto_err <= (m_rlast != (beat_cnt_reg == m_arlen)) ||
                                     (m_rid != ID_W'(owner_reg));
                        if (m_rlast) begin
                            state_reg  <= IDLE;
                            rr_ptr_reg <= (owner_reg == PW'(N_REQ - 1)) ? '0 : owner_reg + PW'(1);
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_rd_arb.sv
// Randomized bench for axi_rd_arb: drives requesters and an AXI slave, checks against a burst-level model.
module tb_axi_rd_arb;

    localparam int N_REQ  = 2;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int ID_W   = 4;

    logic                    clk = 1'b0;
    logic                    reset_n;
    logic [N_REQ-1:0]        req_arvalid;
    logic [N_REQ*ADDR_W-1:0] req_araddr;
    logic [N_REQ*8-1:0]      req_arlen;
    logic [N_REQ-1:0]        req_arready;
    logic [N_REQ-1:0]        req_rvalid;
    logic [N_REQ-1:0]        req_rready;
    logic [DATA_W-1:0]       req_rdata;
    logic [1:0]              req_rresp;
    logic                    req_rlast;
    logic                    m_arvalid;
    logic                    m_arready;
    logic [ADDR_W-1:0]       m_araddr;
    logic [7:0]              m_arlen;
    logic [ID_W-1:0]         m_arid;
    logic [1:0]              m_arburst;
    logic                    m_rvalid;
    logic                    m_rready;
    logic [DATA_W-1:0]       m_rdata;
    logic [1:0]              m_rresp;
    logic                    m_rlast;
    logic [ID_W-1:0]         m_rid;
    logic                    busy;
    logic                    proto_err;

    always #5 clk = ~clk;

    axi_rd_arb #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_arvalid(req_arvalid), .req_araddr(req_araddr), .req_arlen(req_arlen),
        .req_arready(req_arready), .req_rvalid(req_rvalid), .req_rready(req_rready),
        .req_rdata(req_rdata), .req_rresp(req_rresp), .req_rlast(req_rlast),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
        .m_arid(m_arid), .m_arburst(m_arburst), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rid(m_rid),
        .busy(busy), .proto_err(proto_err)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: pending requests per requester, round-robin pointer, pending error pulse.
    int                rr_ptr;
    bit                pend [N_REQ];
    logic [ADDR_W-1:0] paddr [N_REQ];
    logic [7:0]        plen  [N_REQ];
    bit                exp_err;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic pack_reqs();
        for (int i = 0; i < N_REQ; i++) begin
            req_arvalid[i]               = pend[i];
            req_araddr[i*ADDR_W +: ADDR_W] = paddr[i];
            req_arlen[i*8 +: 8]          = plen[i];
        end
    endtask

    task automatic refill(input bit force_all);
        for (int i = 0; i < N_REQ; i++) begin
            if (!pend[i] && (force_all || ($urandom % 3) != 0)) begin
                pend[i]  = 1'b1;
                paddr[i] = $urandom;
                plen[i]  = 8'($urandom_range(0, 5));
            end
        end
    endtask

    task automatic check_reset_outs(input string tag);
        check_eq({tag, "_arvalid"}, 64'(m_arvalid), 64'd0);
        check_eq({tag, "_rready"}, 64'(m_rready), 64'd0);
        check_eq({tag, "_arready"}, 64'(req_arready), 64'd0);
        check_eq({tag, "_rvalid"}, 64'(req_rvalid), 64'd0);
        check_eq({tag, "_busy"}, 64'(busy), 64'd0);
        check_eq({tag, "_err"}, 64'(proto_err), 64'd0);
        check_eq({tag, "_araddr"}, 64'(m_araddr), 64'd0);
        check_eq({tag, "_arlen"}, 64'(m_arlen), 64'd0);
        check_eq({tag, "_arid"}, 64'(m_arid), 64'd0);
        check_eq({tag, "_arburst"}, 64'(m_arburst), 64'd1);
    endtask

    // Cycle with nothing requested while the slave spuriously presents read data.
    task automatic idle_cycle();
        @(negedge clk);
        req_arvalid = '0;
        m_arready   = 1'b1;
        m_rvalid    = 1'b1;
        m_rlast     = 1'b1;
        req_rready  = '1;
        #1;
        check_eq("idle_busy", 64'(busy), 64'd0);
        check_eq("idle_rready", 64'(m_rready), 64'd0);
        check_eq("idle_rvalid", 64'(req_rvalid), 64'd0);
        check_eq("idle_arready", 64'(req_arready), 64'd0);
        check_eq("idle_err", 64'(proto_err), 64'(exp_err));
        exp_err = 1'b0;
    endtask

    task automatic do_grant(output int win);
        logic [63:0] exp_gnt;
        @(negedge clk);
        pack_reqs();
        m_arready  = 1'($urandom);
        m_rvalid   = 1'($urandom);
        m_rlast    = 1'($urandom);
        req_rready = N_REQ'($urandom);
        #1;
        win = -1;
        for (int k = 0; k < N_REQ; k++) begin
            if (win < 0 && pend[(rr_ptr + k) % N_REQ]) win = (rr_ptr + k) % N_REQ;
        end
        exp_gnt = 64'd1 << win;
        check_eq("grant", 64'(req_arready), exp_gnt);
        check_eq("grant_busy", 64'(busy), 64'd0);
        check_eq("grant_arvalid", 64'(m_arvalid), 64'd0);
        check_eq("grant_rvalid", 64'(req_rvalid), 64'd0);
        check_eq("grant_rready", 64'(m_rready), 64'd0);
        check_eq("grant_err", 64'(proto_err), 64'(exp_err));
        exp_err  = 1'b0;
        pend[win] = 1'b0;
    endtask

    task automatic do_ar(input int win, input int delay);
        for (int c = 0; c <= delay; c++) begin
            @(negedge clk);
            pack_reqs();
            m_arready  = (c == delay);
            m_rvalid   = 1'($urandom);
            req_rready = N_REQ'($urandom);
            #1;
            check_eq("ar_valid", 64'(m_arvalid), 64'd1);
            check_eq("ar_addr", 64'(m_araddr), 64'(paddr[win]));
            check_eq("ar_len", 64'(m_arlen), 64'(plen[win]));
            check_eq("ar_id", 64'(m_arid), 64'(win));
            check_eq("ar_busy", 64'(busy), 64'd1);
            check_eq("ar_arready", 64'(req_arready), 64'd0);
            check_eq("ar_rvalid", 64'(req_rvalid), 64'd0);
            check_eq("ar_rready", 64'(m_rready), 64'd0);
            check_eq("ar_err", 64'(proto_err), 64'(exp_err));
            exp_err = 1'b0;
        end
    endtask

    // mode: 0 normal, 1 early RLAST, 2 late RLAST, 3 one beat with a foreign RID
    task automatic do_r(input int win, input int mode);
        int  k = 0;
        int  len = int'(plen[win]);
        int  last_at = len;
        int  bad_beat = -1;
        bit  done = 1'b0;
        bit  hs;
        logic [63:0] exp_rv;
        if (mode == 1 && len >= 1) last_at = $urandom_range(0, len - 1);
        if (mode == 2) last_at = len + 1;
        if (mode == 3) bad_beat = $urandom_range(0, last_at);
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            pack_reqs();
            m_arready  = 1'($urandom);
            m_rvalid   = ($urandom % 4) != 0;
            req_rready = N_REQ'($urandom);
            if (($urandom % 4) != 0) req_rready[win] = 1'b1;
            m_rdata = $urandom;
            m_rresp = 2'($urandom);
            m_rlast = (k == last_at);
            m_rid   = (k == bad_beat) ? ID_W'(win ^ 1) : ID_W'(win);
            #1;
            exp_rv = m_rvalid ? (64'd1 << win) : 64'd0;
            check_eq("r_rvalid", 64'(req_rvalid), exp_rv);
            check_eq("r_rready", 64'(m_rready), 64'(req_rready[win]));
            check_eq("r_rdata", 64'(req_rdata), 64'(m_rdata));
            check_eq("r_rresp", 64'(req_rresp), 64'(m_rresp));
            check_eq("r_rlast", 64'(req_rlast), 64'(m_rlast));
            check_eq("r_arready", 64'(req_arready), 64'd0);
            check_eq("r_busy", 64'(busy), 64'd1);
            check_eq("r_err", 64'(proto_err), 64'(exp_err));
            exp_err = 1'b0;
            hs = m_rvalid && req_rready[win];
            if (hs) begin
                exp_err = (m_rlast && k != len) || (!m_rlast && k == len) || (int'(m_rid) != win);
                if (m_rlast) done = 1'b1;
                k++;
            end
        end
        if (!done) check_eq("r_timeout", 64'd0, 64'd1);
        rr_ptr = (win + 1) % N_REQ;
    endtask

    task automatic do_txn(input int it);
        int win;
        int m;
        bit any;
        refill(1'b0);
        any = 1'b0;
        for (int i = 0; i < N_REQ; i++) any |= pend[i];
        if (!any) begin
            idle_cycle();
            refill(1'b1);
        end
        do_grant(win);
        do_ar(win, (it % 7 == 3) ? 5 : $urandom_range(0, 3));
        m = $urandom % 6;
        do_r(win, (m < 3) ? 0 : m - 2);
    endtask

    initial begin
        int win;
        reset_n     = 1'b0;
        req_arvalid = '0;
        req_araddr  = '0;
        req_arlen   = '0;
        req_rready  = '1;
        m_arready   = 1'b1;
        m_rvalid    = 1'b1;
        m_rdata     = '0;
        m_rresp     = '0;
        m_rlast     = 1'b1;
        m_rid       = '0;
        rr_ptr      = 0;
        exp_err     = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            pend[i]  = 1'b0;
            paddr[i] = '0;
            plen[i]  = '0;
        end
        @(negedge clk);
        @(negedge clk);
        #1;
        check_reset_outs("rst0");
        reset_n = 1'b1;

        for (int it = 0; it < 40; it++) do_txn(it);

        // Reset in the middle of a burst owned by requester 1; afterwards the pointer restarts at 0.
        for (int g = 0; g < 4 && rr_ptr != 1; g++) do_txn(g);
        refill(1'b1);
        do_grant(win);
        do_ar(win, 0);
        @(negedge clk);
        pack_reqs();
        reset_n    = 1'b0;
        m_rvalid   = 1'b1;
        m_rlast    = 1'b0;
        req_rready = '1;
        m_rid      = ID_W'(win);
        @(negedge clk);
        #1;
        check_reset_outs("rst_mid");
        req_arvalid = '0;
        for (int i = 0; i < N_REQ; i++) pend[i] = 1'b0;
        rr_ptr  = 0;
        exp_err = 1'b0;
        reset_n = 1'b1;
        refill(1'b1);
        do_grant(win);
        do_ar(win, 1);
        do_r(win, 0);
        idle_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
